// File: rtl/branch_resolve_unit.sv
// Resolves branch/jump outcomes against branch_comp results, predicts with a bimodal 2-bit PHT,
// and registers PCSel/mispredict for the PC-select stage (1-cycle latency, valid/ready hold).
module branch_resolve_unit #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic [2:0]       funct3,
  input  logic [31:0]      pc,
  output logic             BrUn,
  input  logic             Eq,
  input  logic             Lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             PCSel,
  output logic             pred_taken,
  output logic             mispredict,
  output logic             illegal_f3,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int N = 1 << IDX_W;

  logic [1:0]       pht_q [N];
  logic             out_valid_q, out_valid_d;
  logic             pcsel_q, pcsel_d;
  logic             pred_q, pred_d;
  logic             misp_q, misp_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] idx;
  logic [1:0]       ctr;
  logic             accept;
  logic             f3_bad;
  logic             cond;
  logic             is_br_only;
  logic             pht_wr;
  logic [1:0]       ctr_new;
  logic             unused_pc;

  assign unused_pc  = ^{pc[31:IDX_W+2], pc[1:0]};
  assign idx        = pc[IDX_W+1:2];
  assign ctr        = pht_q[idx];
  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign BrUn       = (funct3[2:1] == 2'b11);
  assign f3_bad     = (funct3[2:1] == 2'b01);
  assign is_br_only = is_branch && !is_jump;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:          cond = Eq;
      3'b001:          cond = !Eq;
      3'b100, 3'b110:  cond = Lt;
      3'b101, 3'b111:  cond = !Lt;
      default:         cond = 1'b0;
    endcase
  end

  always_comb begin
    pcsel_d = pcsel_q;
    pred_d  = pred_q;
    misp_d  = misp_q;
    ill_d   = ill_q;
    if (accept) begin
      pcsel_d = 1'b0;
      pred_d  = 1'b0;
      misp_d  = 1'b0;
      ill_d   = 1'b0;
      if (is_jump) begin
        pcsel_d = 1'b1;
        pred_d  = 1'b1;
      end else if (is_branch) begin
        // cond is already 0 for the reserved funct3 codes, so mispredict reduces to pred_taken
        pcsel_d = cond;
        pred_d  = ctr[1];
        misp_d  = ctr[1] != cond;
        ill_d   = f3_bad;
      end
    end
  end

  always_comb begin
    if (accept) out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else out_valid_d = out_valid_q;
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (accept && is_br_only && !(&branch_cnt_q))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (accept && is_br_only && misp_d && !(&mispred_cnt_q))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  assign pht_wr = accept && is_br_only && !f3_bad;

  always_comb begin
    ctr_new = ctr;
    if (cond && ctr != 2'b11) ctr_new = ctr + 2'b01;
    else if (!cond && ctr != 2'b00) ctr_new = ctr - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      pcsel_q       <= 1'b0;
      pred_q        <= 1'b0;
      misp_q        <= 1'b0;
      ill_q         <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < N; i++) pht_q[i] <= 2'b01;
    end else begin
      out_valid_q   <= out_valid_d;
      pcsel_q       <= pcsel_d;
      pred_q        <= pred_d;
      misp_q        <= misp_d;
      ill_q         <= ill_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (pht_wr) pht_q[idx] <= ctr_new;
    end
  end

  assign out_valid   = out_valid_q;
  assign PCSel       = pcsel_q;
  assign pred_taken  = pred_q;
  assign mispredict  = misp_q;
  assign illegal_f3  = ill_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus backpressure, back-to-back and reset sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, is_branch, is_jump;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic        BrUn, Eq, Lt, out_valid, out_ready;
  logic        PCSel, pred_taken, mispredict, illegal_f3;
  logic [31:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.IDX_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jump(is_jump), .funct3(funct3), .pc(pc),
    .BrUn(BrUn), .Eq(Eq), .Lt(Lt), .out_valid(out_valid), .out_ready(out_ready),
    .PCSel(PCSel), .pred_taken(pred_taken), .mispredict(mispredict),
    .illegal_f3(illegal_f3), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        br;
    bit        jp;
    bit [2:0]  f3;
    bit [31:0] pc;
    bit        eq;
    bit        lt;
    bit        e_brun;
    bit        e_pcsel;
    bit        e_pred;
    bit        e_misp;
    bit        e_ill;
    int        e_b;
    int        e_m;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit br, input bit jp, input bit [2:0] f3, input bit [31:0] p,
                       input bit eq, input bit lt);
    in_valid = 1'b1; is_branch = br; is_jump = jp; funct3 = f3; pc = p; Eq = eq; Lt = lt;
  endtask

  initial begin
    //            br jp f3      pc     eq lt  brun pcs pred misp ill  b   m
    vec[0]  = '{1, 0, 3'b000, 32'h00, 1, 0,  0,  1,  0,  1,  0,  1,  1};
    vec[1]  = '{1, 0, 3'b110, 32'h08, 0, 1,  1,  1,  0,  1,  0,  2,  2};
    vec[2]  = '{1, 0, 3'b101, 32'h0C, 0, 1,  0,  0,  0,  0,  0,  3,  2};
    vec[3]  = '{1, 0, 3'b001, 32'h44, 0, 0,  0,  1,  0,  1,  0,  4,  3};
    vec[4]  = '{1, 0, 3'b001, 32'h44, 0, 0,  0,  1,  1,  0,  0,  5,  3};
    vec[5]  = '{1, 0, 3'b001, 32'h44, 0, 0,  0,  1,  1,  0,  0,  6,  3};
    vec[6]  = '{1, 0, 3'b001, 32'h44, 1, 0,  0,  0,  1,  1,  0,  7,  4};
    vec[7]  = '{1, 0, 3'b001, 32'h44, 0, 0,  0,  1,  1,  0,  0,  8,  4};
    vec[8]  = '{0, 1, 3'b000, 32'h0C, 0, 0,  0,  1,  1,  0,  0,  8,  4};
    vec[9]  = '{1, 0, 3'b010, 32'h00, 1, 0,  0,  0,  1,  1,  1,  9,  5};
    vec[10] = '{1, 0, 3'b011, 32'h00, 1, 0,  0,  0,  1,  1,  1, 10,  6};
    vec[11] = '{1, 0, 3'b100, 32'h10, 0, 1,  0,  1,  0,  1,  0, 11,  7};
    vec[12] = '{1, 0, 3'b111, 32'h14, 0, 0,  1,  1,  0,  1,  0, 12,  8};
    vec[13] = '{0, 0, 3'b111, 32'h14, 0, 0,  1,  0,  0,  0,  0, 12,  8};
    vec[14] = '{1, 0, 3'b000, 32'h14, 0, 0,  0,  0,  1,  1,  0, 13,  9};
    vec[15] = '{1, 1, 3'b010, 32'h0C, 0, 0,  0,  1,  1,  0,  0, 13,  9};

    rst = 1'b1; in_valid = 1'b0; is_branch = 1'b0; is_jump = 1'b0; funct3 = 3'b000;
    pc = '0; Eq = 1'b0; Lt = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_pcsel", {31'b0, PCSel}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vec[i].br, vec[i].jp, vec[i].f3, vec[i].pc, vec[i].eq, vec[i].lt);
      #1;
      chk($sformatf("v%0d_brun", i), {31'b0, BrUn}, {31'b0, vec[i].e_brun});
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 1);
      chk($sformatf("v%0d_pcsel", i), {31'b0, PCSel}, {31'b0, vec[i].e_pcsel});
      chk($sformatf("v%0d_pred", i), {31'b0, pred_taken}, {31'b0, vec[i].e_pred});
      chk($sformatf("v%0d_misp", i), {31'b0, mispredict}, {31'b0, vec[i].e_misp});
      chk($sformatf("v%0d_ill", i), {31'b0, illegal_f3}, {31'b0, vec[i].e_ill});
      chk($sformatf("v%0d_bcnt", i), branch_cnt, vec[i].e_b);
      chk($sformatf("v%0d_mcnt", i), mispred_cnt, vec[i].e_m);
      @(negedge clk);
    end
    chk("idle_out_valid", {31'b0, out_valid}, 0);

    // Backpressure: A accepted, B waits two stalled cycles, then goes through.
    out_ready = 1'b0;
    drive(1, 0, 3'b000, 32'h18, 1, 0);
    @(negedge clk);
    drive(1, 0, 3'b001, 32'h1C, 1, 0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hold%0d_out_valid", k), {31'b0, out_valid}, 1);
      chk($sformatf("hold%0d_in_ready", k), {31'b0, in_ready}, 0);
      chk($sformatf("hold%0d_pcsel", k), {31'b0, PCSel}, 1);
      chk($sformatf("hold%0d_misp", k), {31'b0, mispredict}, 1);
      chk($sformatf("hold%0d_bcnt", k), branch_cnt, 14);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b_out_valid", {31'b0, out_valid}, 1);
    chk("b_pcsel", {31'b0, PCSel}, 0);
    chk("b_misp", {31'b0, mispredict}, 0);
    chk("b_bcnt", branch_cnt, 15);
    chk("b_mcnt", mispred_cnt, 10);
    @(negedge clk);
    chk("b_drain_out_valid", {31'b0, out_valid}, 0);

    // Back-to-back: one result per cycle with no bubbles.
    drive(1, 0, 3'b000, 32'h20, 1, 0);
    @(negedge clk);
    drive(1, 0, 3'b000, 32'h24, 0, 0);
    chk("bb0_out_valid", {31'b0, out_valid}, 1);
    chk("bb0_pcsel", {31'b0, PCSel}, 1);
    @(negedge clk);
    drive(1, 0, 3'b000, 32'h28, 1, 0);
    chk("bb1_out_valid", {31'b0, out_valid}, 1);
    chk("bb1_pcsel", {31'b0, PCSel}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bb2_out_valid", {31'b0, out_valid}, 1);
    chk("bb2_pcsel", {31'b0, PCSel}, 1);
    chk("bb2_bcnt", branch_cnt, 18);
    chk("bb2_mcnt", mispred_cnt, 12);
    @(negedge clk);

    // Reset while a result is held, then pc=0x40 (aliases idx 0) predicts not-taken again.
    out_ready = 1'b0;
    drive(1, 0, 3'b001, 32'h00, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_out_valid", {31'b0, out_valid}, 1);
    chk("pre_rst_pred", {31'b0, pred_taken}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_pcsel", {31'b0, PCSel}, 0);
    chk("mid_rst_pred", {31'b0, pred_taken}, 0);
    chk("mid_rst_bcnt", branch_cnt, 0);
    chk("mid_rst_mcnt", mispred_cnt, 0);
    out_ready = 1'b1;
    drive(1, 0, 3'b001, 32'h40, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_out_valid", {31'b0, out_valid}, 1);
    chk("post_rst_pred", {31'b0, pred_taken}, 0);
    chk("post_rst_misp", {31'b0, mispredict}, 1);
    chk("post_rst_bcnt", branch_cnt, 1);
    chk("post_rst_mcnt", mispred_cnt, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
